// File: rtl/i2c_target_regfile_pkg.sv
// Shared definitions for the I2C target register file: FSM encoding, default
// bus address, register index constants and the pointer wrap helper.
package i2c_target_regfile_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 4;

  localparam logic [6:0]  DEFAULT_DEV_ADDR  = 7'h68;
  localparam int unsigned DEFAULT_REG_COUNT = 19;

  // Timekeeping register map
  localparam logic [ADDR_W-1:0] REG_SEC      = 5'h00;
  localparam logic [ADDR_W-1:0] REG_MIN      = 5'h01;
  localparam logic [ADDR_W-1:0] REG_HOUR     = 5'h02;
  localparam logic [ADDR_W-1:0] REG_TEMP_LSB = 5'h12;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RACK_WAIT
  } state_e;

  // Register pointer increment with wrap at the end of the register file
  function automatic logic [ADDR_W-1:0] ptr_next(input logic [ADDR_W-1:0] p,
                                                 input int unsigned       count);
    return ((32'(p) + 32'd1) >= count) ? '0 : p + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronisers for SCL/SDA, SCL edge detect and START/STOP detect.
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic scl,
  input  logic sda,
  output logic sda_s,
  output logic scl_rise_c,
  output logic scl_fall_c,
  output logic start_c,
  output logic stop_c
);

  logic [1:0] scl_ff;
  logic [1:0] sda_ff;
  logic       scl_d;
  logic       sda_d;

  // Idle bus level is high, so everything resets high to avoid false edges
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      scl_ff <= 2'b11;
      sda_ff <= 2'b11;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_ff <= {scl_ff[0], scl};
      sda_ff <= {sda_ff[0], sda};
      scl_d  <= scl_ff[1];
      sda_d  <= sda_ff[1];
    end
  end

  assign sda_s      = sda_ff[1];
  assign scl_rise_c =  scl_ff[1] & ~scl_d;
  assign scl_fall_c = ~scl_ff[1] &  scl_d;
  assign start_c    =  scl_ff[1] & scl_d & sda_d & ~sda_ff[1];
  assign stop_c     =  scl_ff[1] & scl_d & ~sda_d & sda_ff[1];

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target exposing REG_COUNT 8-bit registers with an auto-incrementing
// pointer, plus a local write port from the on-chip timekeeping logic.
module i2c_target_regfile
  import i2c_target_regfile_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR  = DEFAULT_DEV_ADDR,
  parameter int unsigned REG_COUNT = DEFAULT_REG_COUNT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i2c_scl,
  inout  wire               i2c_sda,
  input  logic              i_loc_wr_en,
  input  logic [ADDR_W-1:0] i_loc_wr_addr,
  input  logic [DATA_W-1:0] i_loc_wr_data,
  output logic              o_wr_strobe,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [DATA_W-1:0] o_wr_data,
  output logic              o_busy
);

  logic sda_s, scl_rise_c, scl_fall_c, start_c, stop_c;

  i2c_bus_sync u_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .scl        (i2c_scl),
    .sda        (i2c_sda),
    .sda_s      (sda_s),
    .scl_rise_c (scl_rise_c),
    .scl_fall_c (scl_fall_c),
    .start_c    (start_c),
    .stop_c     (stop_c)
  );

  state_e            state, state_n;
  logic [CNT_W-1:0]  bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [ADDR_W-1:0] ptr, ptr_n;
  logic              rw, rw_n;
  logic              rack_ok, rack_n;
  logic              sda_oe, sda_oe_n;
  logic              busy_n, wr_stb_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [DATA_W-1:0] wr_data_n;
  logic [DATA_W-1:0] regs [REG_COUNT];
  logic [DATA_W-1:0] rd_byte;
  logic              byte_done;

  assign rd_byte   = regs[ptr];
  assign byte_done = (bit_cnt == CNT_W'(8));
  assign i2c_sda   = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Bits are taken on SCL rise; SDA is only ever changed on SCL fall
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    ptr_n     = ptr;
    rw_n      = rw;
    rack_n    = rack_ok;
    sda_oe_n  = sda_oe;
    busy_n    = o_busy;
    wr_stb_n  = 1'b0;
    wr_addr_n = o_wr_addr;
    wr_data_n = o_wr_data;
    if (stop_c) begin
      state_n  = ST_IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start_c) begin
      state_n   = ST_ADDR;
      bit_cnt_n = '0;
      sda_oe_n  = 1'b0;
      rack_n    = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: ;
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise_c && !byte_done) begin
            shreg_n   = {shreg[DATA_W-2:0], sda_s};
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end else if (scl_fall_c && byte_done) begin
            bit_cnt_n = '0;
            if (state == ST_ADDR) begin
              if (shreg[DATA_W-1:1] == DEV_ADDR) begin
                state_n  = ST_ADDR_ACK;
                sda_oe_n = 1'b1;
                busy_n   = 1'b1;
                rw_n     = shreg[0];
              end else begin
                state_n  = ST_IDLE;
              end
            end else if (state == ST_PTR) begin
              state_n  = ST_PTR_ACK;
              sda_oe_n = 1'b1;
              ptr_n    = (32'(shreg) >= REG_COUNT) ? '0 : shreg[ADDR_W-1:0];
            end else begin
              state_n   = ST_WDATA_ACK;
              sda_oe_n  = 1'b1;
              wr_stb_n  = 1'b1;
              wr_addr_n = ptr;
              wr_data_n = shreg;
              ptr_n     = ptr_next(ptr, REG_COUNT);
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall_c) begin
            bit_cnt_n = '0;
            if (rw) begin
              state_n  = ST_RDATA;
              shreg_n  = rd_byte;
              sda_oe_n = ~rd_byte[DATA_W-1];
            end else begin
              state_n  = ST_PTR;
              sda_oe_n = 1'b0;
            end
          end
        end
        ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall_c) begin
            state_n   = ST_WDATA;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
          end
        end
        ST_RDATA: begin
          if (scl_rise_c && !byte_done) begin
            bit_cnt_n = bit_cnt + CNT_W'(1);
          end else if (scl_fall_c) begin
            if (byte_done) begin
              state_n  = ST_RACK_WAIT;
              sda_oe_n = 1'b0;
              rack_n   = 1'b0;
              ptr_n    = ptr_next(ptr, REG_COUNT);
            end else begin
              sda_oe_n = ~shreg[DATA_W-2];
              shreg_n  = {shreg[DATA_W-2:0], 1'b0};
            end
          end
        end
        ST_RACK_WAIT: begin
          if (scl_rise_c) begin
            if (sda_s) state_n = ST_IDLE;
            else       rack_n  = 1'b1;
          end else if (scl_fall_c && rack_ok) begin
            state_n   = ST_RDATA;
            bit_cnt_n = '0;
            shreg_n   = rd_byte;
            sda_oe_n  = ~rd_byte[DATA_W-1];
            rack_n    = 1'b0;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt     <= '0;
      shreg       <= '0;
      ptr         <= '0;
      rw          <= 1'b0;
      rack_ok     <= 1'b0;
      sda_oe      <= 1'b0;
      o_busy      <= 1'b0;
      o_wr_strobe <= 1'b0;
      o_wr_addr   <= '0;
      o_wr_data   <= '0;
    end else begin
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      ptr         <= ptr_n;
      rw          <= rw_n;
      rack_ok     <= rack_n;
      sda_oe      <= sda_oe_n;
      o_busy      <= busy_n;
      o_wr_strobe <= wr_stb_n;
      o_wr_addr   <= wr_addr_n;
      o_wr_data   <= wr_data_n;
    end
  end

  // The I2C write is placed last so it overrides a same-address local write
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs[ADDR_W'(i)] <= '0;
    end else begin
      if (i_loc_wr_en && (32'(i_loc_wr_addr) < REG_COUNT))
        regs[i_loc_wr_addr] <= i_loc_wr_data;
      if (o_wr_strobe)
        regs[o_wr_addr] <= o_wr_data;
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Directed bench for i2c_target_regfile: bit-banged I2C initiator, strobe log
// and hand-computed expected register contents.
module tb_i2c_target_regfile;
  import i2c_target_regfile_pkg::*;

  localparam int unsigned Q = 50;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        sda_low;
  logic        loc_en;
  logic [4:0]  loc_addr;
  logic [7:0]  loc_data;
  logic        wr_strobe;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  tri1         sda_bus;

  int          checks = 0;
  int          errors = 0;
  logic [12:0] stb_q[$];
  int          dut_low_cnt = 0;
  logic        watch = 1'b0;
  logic        ack;
  logic        seen;
  logic [23:0] rd;

  assign sda_bus = sda_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target_regfile dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i2c_scl       (scl),
    .i2c_sda       (sda_bus),
    .i_loc_wr_en   (loc_en),
    .i_loc_wr_addr (loc_addr),
    .i_loc_wr_data (loc_data),
    .o_wr_strobe   (wr_strobe),
    .o_wr_addr     (wr_addr),
    .o_wr_data     (wr_data),
    .o_busy        (busy)
  );

  always @(negedge clk) if (wr_strobe) stb_q.push_back({wr_addr, wr_data});
  always @(negedge clk) if (watch && !sda_low && sda_bus === 1'b0) dut_low_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_start();
    sda_low = 1'b0; #Q; scl = 1'b1; #Q; sda_low = 1'b1; #Q; scl = 1'b0; #Q;
  endtask

  task automatic bus_stop();
    sda_low = 1'b1; #Q; scl = 1'b1; #Q; sda_low = 1'b0; #(2*Q);
  endtask

  task automatic put_bit(input logic b);
    sda_low = !b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    sda_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda_bus; #Q; scl = 1'b0; #Q;
  endtask

  task automatic put_byte(input logic [7:0] d, output logic a);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(a);
  endtask

  task automatic get_byte(input logic nack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  task automatic local_wr(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk); loc_en = 1'b1; loc_addr = a; loc_data = d;
    @(negedge clk); loc_en = 1'b0;
  endtask

  task automatic reg_write(input string tag, input logic [7:0] p, input logic [7:0] d0,
                           input logic [7:0] d1, input int n);
    logic a;
    bus_start();
    put_byte(8'hD0, a); check_eq({tag, "_ack_addr"}, 32'(a), 32'd0);
    put_byte(p, a);     check_eq({tag, "_ack_ptr"},  32'(a), 32'd0);
    put_byte(d0, a);    check_eq({tag, "_ack_d0"},   32'(a), 32'd0);
    if (n > 1) begin
      put_byte(d1, a);  check_eq({tag, "_ack_d1"},   32'(a), 32'd0);
    end
    bus_stop();
  endtask

  task automatic reg_read(input string tag, input logic set_ptr, input logic [7:0] p,
                          input int n, output logic [23:0] r);
    logic a;
    logic [7:0] b;
    r = '0;
    bus_start();
    if (set_ptr) begin
      put_byte(8'hD0, a); check_eq({tag, "_ack_w"}, 32'(a), 32'd0);
      put_byte(p, a);     check_eq({tag, "_ack_p"}, 32'(a), 32'd0);
      bus_start();
    end
    put_byte(8'hD1, a);   check_eq({tag, "_ack_r"}, 32'(a), 32'd0);
    for (int i = 0; i < n; i++) begin
      get_byte(i == n - 1, b);
      r = {r[15:0], b};
    end
    bus_stop();
  endtask

  initial begin
    rst = 1'b1; scl = 1'b1; sda_low = 1'b0;
    loc_en = 1'b0; loc_addr = '0; loc_data = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy",    32'(busy),      32'd0);
    check_eq("rst_strobe",  32'(wr_strobe), 32'd0);
    check_eq("rst_wr_addr", 32'(wr_addr),   32'd0);
    check_eq("rst_wr_data", 32'(wr_data),   32'd0);
    check_eq("rst_sda",     32'(sda_bus),   32'd1);

    // Basic write of the seconds register
    bus_start();
    put_byte(8'hD0, ack);          check_eq("t1_ack_addr", 32'(ack), 32'd0);
    check_eq("t1_busy_mid", 32'(busy), 32'd1);
    put_byte(8'(REG_SEC), ack);    check_eq("t1_ack_ptr", 32'(ack), 32'd0);
    put_byte(8'h30, ack);          check_eq("t1_ack_data", 32'(ack), 32'd0);
    bus_stop();
    check_eq("t1_busy_end", 32'(busy), 32'd0);
    check_eq("t1_stb_cnt", 32'(stb_q.size()), 32'd1);
    if (stb_q.size() > 0) check_eq("t1_stb0", 32'(stb_q[0]), 32'({5'h00, 8'h30}));
    stb_q.delete();
    reg_write("t1b", 8'(REG_MIN), 8'h5A, 8'h00, 1);
    stb_q.delete();

    // Repeated-start read, then current-address read shows the pointer moved to 1
    reg_read("t2", 1'b1, 8'h00, 1, rd);
    check_eq("t2_rd", 32'(rd), 32'h30);
    reg_read("t2c", 1'b0, 8'h00, 1, rd);
    check_eq("t2c_rd_ptr1", 32'(rd), 32'h5A);

    // Write across the end of the register file, then read across it
    reg_write("t3", 8'(REG_TEMP_LSB), 8'hAA, 8'hBB, 2);
    check_eq("t3_stb_cnt", 32'(stb_q.size()), 32'd2);
    if (stb_q.size() > 1) begin
      check_eq("t3_stb0", 32'(stb_q[0]), 32'({5'h12, 8'hAA}));
      check_eq("t3_stb1", 32'(stb_q[1]), 32'({5'h00, 8'hBB}));
    end
    stb_q.delete();
    reg_read("t3r", 1'b1, 8'h11, 3, rd);
    check_eq("t3r_rd3", 32'(rd), 32'h00AABB);
    reg_read("t3c", 1'b0, 8'h00, 1, rd);
    check_eq("t3c_rd_wrap", 32'(rd), 32'h5A);

    // Out-of-range pointer loads 0
    reg_read("t4a", 1'b1, 8'h20, 1, rd);
    check_eq("t4a_rd", 32'(rd), 32'hBB);
    reg_read("t4b", 1'b1, 8'h13, 1, rd);
    check_eq("t4b_rd", 32'(rd), 32'hBB);

    // Foreign address: never acknowledged or driven
    watch = 1'b1;
    bus_start();
    put_byte(8'hA0, ack);          check_eq("t5_nak_addr", 32'(ack), 32'd1);
    check_eq("t5_busy", 32'(busy), 32'd0);
    put_byte(8'h00, ack);          check_eq("t5_nak_data", 32'(ack), 32'd1);
    bus_stop();
    watch = 1'b0;
    check_eq("t5_sda_driven", 32'(dut_low_cnt), 32'd0);
    check_eq("t5_stb_cnt", 32'(stb_q.size()), 32'd0);

    // Same-cycle local and I2C write to register 0
    seen = 1'b0;
    fork
      reg_write("t6", 8'h00, 8'h30, 8'h00, 1);
      begin
        for (int i = 0; i < 5000 && !seen; i++) begin
          @(negedge clk);
          if (wr_strobe) seen = 1'b1;
        end
        if (seen) begin
          loc_en = 1'b1; loc_addr = 5'h00; loc_data = 8'h59;
          @(negedge clk);
          loc_en = 1'b0;
        end
      end
    join
    check_eq("t6_strobe_seen", 32'(seen), 32'd1);
    stb_q.delete();
    reg_read("t6r", 1'b1, 8'h00, 1, rd);
    check_eq("t6r_i2c_wins", 32'(rd), 32'h30);

    // Local write while register 0 is being shifted out
    fork
      reg_read("t6f", 1'b1, 8'h00, 1, rd);
      begin #(128*Q); local_wr(5'h00, 8'h77); end
    join
    check_eq("t6f_in_flight", 32'(rd), 32'h30);
    reg_read("t6n", 1'b1, 8'h00, 1, rd);
    check_eq("t6n_new_value", 32'(rd), 32'h77);

    // Reset during bit 4 of a data byte (0xB5)
    bus_start();
    put_byte(8'hD0, ack);          check_eq("t7_ack_addr", 32'(ack), 32'd0);
    put_byte(8'h00, ack);          check_eq("t7_ack_ptr", 32'(ack), 32'd0);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    sda_low = 1'b0; #Q; scl = 1'b1;
    #10; rst = 1'b1; #30; rst = 1'b0; #10;
    check_eq("t7_sda_rel", 32'(sda_bus), 32'd1);
    check_eq("t7_busy", 32'(busy), 32'd0);
    #50; scl = 1'b0; #Q;
    put_bit(1'b0); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
    get_bit(ack);                  check_eq("t7_ignored", 32'(ack), 32'd1);
    bus_stop();
    check_eq("t7_stb_cnt", 32'(stb_q.size()), 32'd0);
    reg_read("t7z", 1'b1, 8'h00, 1, rd);
    check_eq("t7z_cleared", 32'(rd), 32'h00);
    reg_write("t7w", 8'(REG_HOUR), 8'h42, 8'h00, 1);
    check_eq("t7w_stb_cnt", 32'(stb_q.size()), 32'd1);
    if (stb_q.size() > 0) check_eq("t7w_stb0", 32'(stb_q[0]), 32'({5'h02, 8'h42}));
    reg_read("t7r", 1'b1, 8'(REG_HOUR), 1, rd);
    check_eq("t7r_rd", 32'(rd), 32'h42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target_regfile.md
I2C_TARGET_REGFILE -- requirements
Module: i2c_target_regfile

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h68, the 7-bit target address answered on the bus.
REQ-002 SHALL have parameter REG_COUNT, default 19, the number of 8-bit registers (0x00..REG_COUNT-1).
REQ-003 i_clk  input  1  system clock; one clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i2c_scl  input  1  bus clock from the initiator (the target does no clock stretching).
REQ-006 i2c_sda  inout  1  open-drain data; driven 0 or high-Z, never driven 1.
REQ-007 i_loc_wr_en  input  1  local register write strobe, e.g. from the timekeeping counter.
REQ-008 i_loc_wr_addr  input  5  local write address.
REQ-009 i_loc_wr_data  input  8  local write data.
REQ-010 o_wr_strobe  output  1  one-cycle pulse per register written over I2C.
REQ-011 o_wr_addr  output  5  address of the I2C write, valid with o_wr_strobe.
REQ-012 o_wr_data  output  8  data of the I2C write, valid with o_wr_strobe.
REQ-013 o_busy  output  1  high from an addressed START until STOP.

Function
REQ-014 SHALL synchronise SCL and SDA through 2 flops each, then detect edges on the synchronised copies.
REQ-015 SHALL treat SDA falling while SCL is high as START, and SDA rising while SCL is high as STOP; either one takes effect in any state.
REQ-016 FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK_WAIT.
REQ-017 START (including a repeated START) SHALL go to ADDR with the bit counter cleared and the register pointer preserved.
REQ-018 STOP SHALL go to IDLE, release SDA, and clear o_busy.
REQ-019 Bits SHALL be sampled on synchronised SCL rising edges, MSB first; 8 bits complete a byte.
REQ-020 ADDR: an address match with R/W=0 SHALL give ADDR_ACK then PTR; a match with R/W=1 SHALL give ADDR_ACK then RDATA.
REQ-021 ADDR: a mismatch SHALL return to IDLE without driving SDA for the rest of the transfer.
REQ-022 During an ACK slot the target SHALL drive SDA low from the SCL falling edge after bit 8 until the next SCL falling edge.
REQ-023 PTR: the received byte SHALL be loaded into the pointer and ACKed; values >= REG_COUNT SHALL load 0.
REQ-024 WDATA: the byte SHALL be written to regs[ptr], o_wr_strobe SHALL pulse once, it SHALL be ACKed, and ptr SHALL increment.
REQ-025 RDATA: regs[ptr] SHALL be latched into the shift register on entry, and each bit SHALL be driven on the SCL falling edge.
REQ-026 After 8 read bits SHALL come RACK_WAIT: SDA released, initiator bit sampled on SCL rising; ACK (0) increments ptr and reloads RDATA; NACK (1) goes to IDLE.
REQ-027 The pointer SHALL wrap from REG_COUNT-1 to 0 on every increment.
REQ-028 A local write SHALL update the register the cycle after i_loc_wr_en; local addresses >= REG_COUNT SHALL be ignored.
REQ-029 If an I2C write and a local write hit the same address in the same cycle, the I2C write SHALL win.
REQ-030 A local write to the register being shifted out SHALL NOT corrupt the byte in flight; the new value appears on the next read.
REQ-031 SDA output SHALL change only on synchronised SCL falling edges, except on release at STOP or reset.

Reset
REQ-032 i_rst SHALL set: FSM to IDLE, SDA released (high-Z), o_busy=0, o_wr_strobe=0, o_wr_addr=0, o_wr_data=0, ptr=0, all registers 8'h00, synchronisers high.
REQ-033 Reset mid-transfer SHALL abort immediately; the target SHALL ignore the bus until the next START.

Structure
REQ-034 A shared package SHALL hold the FSM state encoding, the 7'h68 default address, and the register index constants (SEC=0x00, MIN=0x01, HOUR=0x02, ...).
REQ-035 One sub-module, i2c_bus_sync, SHALL contain the synchroniser, the SCL edge detect, and START/STOP detect.

Verification
REQ-036 Write 0xD0, 0x00, 0x30, STOP -> three ACKs; regs[0]=0x30; one o_wr_strobe with addr=0, data=0x30.
REQ-037 0xD0, 0x00, repeated START, 0xD1, read 1 byte with NACK, STOP -> bits on SDA read back 0x30; ptr=1 afterwards.
REQ-038 0xD0, 0x12, data 0xAA, 0xBB -> regs[0x12]=0xAA, regs[0x00]=0xBB (wrap); then a 3-byte read from 0x11 -> 0x00, 0xAA, 0xBB.
REQ-039 Address 0xA0 (mismatch) -> SDA never driven low; no strobe; o_busy stays 0.
REQ-040 Local write of 0x59 to addr 0 on the same cycle as an I2C write of 0x30 to addr 0 -> regs[0]=0x30; a local write during a read of addr 0 -> byte in flight unchanged.
REQ-041 Assert i_rst during bit 4 of a write byte -> SDA released, FSM in IDLE; a following full transaction succeeds normally.
